// File: rtl/bcd_scan_display.sv
`default_nettype none
// =============================================================================
// Module  : bcd_scan_display
// Brief   : Six-digit packed-BCD scanner for a multiplexed 7-segment bank,
//           with decimal point, leading-zero blanking and per-frame snapshot.
// Revision: 1.0  initial release
// =============================================================================
module bcd_scan_display #(
    parameter logic [15:0] SCAN_DIV    = 16'd49_999,
    parameter logic [2:0]  DP_POS      = 3'd1,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          DIG_ACT_LOW = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [23:0] Number_Sig,
    input  logic        Blank_En,
    output logic [7:0]  Seg_Out,
    output logic [5:0]  Dig_Sel,
    output logic        Frame_Done
);

    localparam logic [2:0] LAST_DIGIT = 3'd5;
    localparam logic [7:0] SEG_OFF    = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [5:0] DIG_OFF    = DIG_ACT_LOW ? 6'h3F : 6'h00;

    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] snap_q, snap_d;
    logic        fd_q, fd_d;
    logic [7:0]  seg_q, seg_d;
    logic [5:0]  dig_q, dig_d;

    logic        w_wrap;
    logic [23:0] w_upper;
    logic [3:0]  w_nib;
    logic [6:0]  w_hex;
    logic        w_dp;
    logic        w_blank;
    logic [7:0]  w_seg_act;
    logic [5:0]  w_dig_act;

    assign w_wrap = (cnt_q == SCAN_DIV);

    always_comb begin
        cnt_d  = w_wrap ? 16'd0 : cnt_q + 16'd1;
        idx_d  = idx_q;
        snap_d = snap_q;
        fd_d   = 1'b0;
        if (w_wrap) begin
            if (idx_q == LAST_DIGIT) begin
                idx_d  = 3'd0;
                snap_d = Number_Sig;
                fd_d   = 1'b1;
            end else begin
                idx_d  = idx_q + 3'd1;
            end
        end
    end

    // Shifting the current digit down to bit 0 leaves it plus every higher
    // digit in w_upper, which is exactly what the blanking test needs.
    assign w_upper = snap_q >> {idx_q, 2'b00};
    assign w_nib   = w_upper[3:0];

    always_comb begin
        case (w_nib)
            4'd0:    w_hex = 7'h3F;
            4'd1:    w_hex = 7'h06;
            4'd2:    w_hex = 7'h5B;
            4'd3:    w_hex = 7'h4F;
            4'd4:    w_hex = 7'h66;
            4'd5:    w_hex = 7'h6D;
            4'd6:    w_hex = 7'h7D;
            4'd7:    w_hex = 7'h07;
            4'd8:    w_hex = 7'h7F;
            4'd9:    w_hex = 7'h6F;
            default: w_hex = 7'h40;
        endcase
    end

    assign w_dp      = (idx_q == DP_POS);
    assign w_blank   = Blank_En && (idx_q > DP_POS) && (w_upper == 24'h0);
    assign w_seg_act = w_blank ? 8'h00 : {w_dp, w_hex};
    assign w_dig_act = 6'd1 << idx_q;

    assign seg_d = SEG_ACT_LOW ? ~w_seg_act : w_seg_act;
    assign dig_d = DIG_ACT_LOW ? ~w_dig_act : w_dig_act;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q  <= 16'd0;
            idx_q  <= 3'd0;
            snap_q <= 24'h0;
            fd_q   <= 1'b0;
            seg_q  <= SEG_OFF;
            dig_q  <= DIG_OFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            fd_q   <= fd_d;
            seg_q  <= seg_d;
            dig_q  <= dig_d;
        end
    end

    assign Seg_Out    = seg_q;
    assign Dig_Sel    = dig_q;
    assign Frame_Done = fd_q;

endmodule
`default_nettype wire
